// File: rtl/mem_stage_pkg.sv
// Shared encodings and types for the memory-access stage and its helpers.
package mem_stage_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_RESP = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic [4:0]  dest_reg_idx;
      logic        reg_wr;
   } mem_wb_t;

   // funct3[1] set selects a full word regardless of funct3[0].
   function automatic logic [1:0] mem_size(input logic [2:0] funct3);
      return funct3[1] ? MEM_WORD : funct3[1:0];
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data lane select and sign/zero extension; purely combinational.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sign_ext;

   always_comb begin
      byte_sel = rdata_i[7:0];
      case (addr_lo_i)
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         2'd3:    byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      sign_ext = ~funct3_i[2];

      result_o = rdata_i;
      case (mem_size(funct3_i))
         MEM_BYTE: result_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
         MEM_HALF: result_o = {{16{sign_ext & half_sel[15]}}, half_sel};
         default:  result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the split req/resp data port, stalls upstream while an access is open.
// Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses instead of issuing them.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_mem_valid_inst,
   input  logic [31:0] ex_mem_alu_result,
   input  logic [31:0] ex_mem_rega,
   input  logic        ex_mem_rd_mem,
   input  logic        ex_mem_wr_mem,
   input  logic [2:0]  ex_mem_funct3,
   input  logic [4:0]  ex_mem_dest_reg_idx,
   input  logic        ex_mem_reg_wr,
   output logic        proc2Dmem_req,
   output logic        proc2Dmem_we,
   output logic [31:0] proc2Dmem_addr,
   output logic [31:0] proc2Dmem_wdata,
   output logic [3:0]  proc2Dmem_be,
   input  logic        Dmem2proc_gnt,
   input  logic        Dmem2proc_rvalid,
   input  logic [31:0] Dmem2proc_rdata,
   output logic        mem_stall_out,
   output logic        mem_wb_valid,
   output logic [31:0] mem_wb_result,
   output logic [4:0]  mem_wb_dest_reg_idx,
   output logic        mem_wb_reg_wr,
   output logic        mem_misalign_out
);

   mem_state_e  state_q, state_d;
   mem_wb_t     wb_q, wb_d;
   logic        memop, misaligned, complete;
   logic [1:0]  size, a_lo;
   logic [31:0] load_data;

   assign memop = ex_mem_valid_inst & (ex_mem_rd_mem | ex_mem_wr_mem);
   assign size  = mem_size(ex_mem_funct3);
   assign a_lo  = ex_mem_alu_result[1:0];

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = ((size == MEM_HALF) & a_lo[0]) |
                       ((size == MEM_WORD) & (a_lo != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      proc2Dmem_req = 1'b0;
      complete      = 1'b0;
      case (state_q)
         IDLE: begin
            // A response arriving here is stale and deliberately ignored.
            proc2Dmem_req = memop & ~misaligned;
            if (proc2Dmem_req & Dmem2proc_gnt) begin
               if (ex_mem_rd_mem) state_d  = WAIT_RESP;
               else               complete = 1'b1;
            end
         end
         WAIT_RESP: begin
            if (Dmem2proc_rvalid) begin
               complete = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_stall_out = memop & ~misaligned & ~complete;

   assign proc2Dmem_we   = ex_mem_wr_mem;
   assign proc2Dmem_addr = {ex_mem_alu_result[31:2], 2'b00};

   always_comb begin
      proc2Dmem_be    = 4'b1111;
      proc2Dmem_wdata = ex_mem_rega;
      case (size)
         MEM_BYTE: begin
            proc2Dmem_be    = 4'b0001 << a_lo;
            proc2Dmem_wdata = {4{ex_mem_rega[7:0]}};
         end
         MEM_HALF: begin
            proc2Dmem_be    = 4'b0011 << {a_lo[1], 1'b0};
            proc2Dmem_wdata = {2{ex_mem_rega[15:0]}};
         end
         default: ;
      endcase
   end

   mem_load_align u_load_align (
      .rdata_i   (Dmem2proc_rdata),
      .addr_lo_i (a_lo),
      .funct3_i  (ex_mem_funct3),
      .result_o  (load_data)
   );

   always_comb begin
      wb_d.valid        = ex_mem_valid_inst & ~(memop & misaligned);
      wb_d.result       = (memop & ex_mem_rd_mem) ? load_data : ex_mem_alu_result;
      wb_d.dest_reg_idx = ex_mem_dest_reg_idx;
      wb_d.reg_wr       = ex_mem_reg_wr & ~(memop & ex_mem_wr_mem) & ~(memop & misaligned);
      if (mem_stall_out) begin
         wb_d.valid  = 1'b0;
         wb_d.reg_wr = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         wb_q    <= wb_d;
      end
   end

   assign mem_wb_valid        = wb_q.valid;
   assign mem_wb_result       = wb_q.result;
   assign mem_wb_dest_reg_idx = wb_q.dest_reg_idx;
   assign mem_wb_reg_wr       = wb_q.reg_wr;

`ifdef MEM_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;
   assign misalign_d = memop & misaligned;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_d;
   end
   assign mem_misalign_out = misalign_q;
`else
   assign mem_misalign_out = 1'b0;
`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the execute stage. Consumes the EX/MEM latch (ALU result used as address or pass-through value, store data, load/store controls), drives a split request/response data-memory port, sizes and extends load data, and produces the registered MEM/WB outputs. While an access is outstanding it stalls the upstream pipeline and presents bubbles to write-back.

## Interface
Parameters:
- none. Widths are fixed at 32-bit data/address and 5-bit register index.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ex_mem_valid_inst  in  1  instruction in EX/MEM is valid
- ex_mem_alu_result  in  32  execute-stage result; address for loads/stores
- ex_mem_rega  in  32  store data (rs2 value)
- ex_mem_rd_mem  in  1  load
- ex_mem_wr_mem  in  1  store
- ex_mem_funct3  in  3  bits [1:0] give size (00 byte, 01 half, 1x word); bit 2 set means unsigned load
- ex_mem_dest_reg_idx  in  5  destination register
- ex_mem_reg_wr  in  1  instruction writes a register
- proc2Dmem_req  out  1  access request
- proc2Dmem_we  out  1  1 = store
- proc2Dmem_addr  out  32  word-aligned address, bits [1:0] = 0
- proc2Dmem_wdata  out  32  lane-replicated store data
- proc2Dmem_be  out  4  byte enables
- Dmem2proc_gnt  in  1  request accepted this cycle
- Dmem2proc_rvalid  in  1  load data valid
- Dmem2proc_rdata  in  32  load data word
- mem_stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_wb_valid  out  1  registered
- mem_wb_result  out  32  registered
- mem_wb_dest_reg_idx  out  5  registered
- mem_wb_reg_wr  out  1  registered
- mem_misalign_out  out  1  registered one-cycle pulse

## Operation
- Memory op: `memop = ex_mem_valid_inst & (rd_mem | wr_mem)`. Asserting both rd_mem and wr_mem is illegal. The bench treats it as an assertion failure.
- FSM states IDLE and WAIT_RESP. Reset enters IDLE.
- IDLE:
  - `req = memop & ~misaligned`.
  - Store with gnt: complete, stay IDLE.
  - Load with gnt: go to WAIT_RESP.
  - No gnt: stay IDLE, keep req high.
- WAIT_RESP:
  - req is 0.
  - On rvalid: extend data, complete, return to IDLE.
- rvalid seen in IDLE is ignored (covers a stale response after reset).
- `mem_stall_out = memop & ~misaligned & ~complete`. It is combinational and deasserts in the completing cycle.
- Request fields are combinational from EX/MEM. They stay stable because EX/MEM is frozen while stalled.
- Byte enables:
  - byte: `0001 << a[1:0]`, wdata = byte replicated ×4.
  - half: `0011 << {a[1],0}`, wdata = half replicated ×2.
  - word: be `1111`.
- Load extract uses the lane selected by a[1:0]. Data is sign- or zero-extended per funct3[2].
- Output register updates on every edge:
  - While stalled: mem_wb_valid = 0, mem_wb_reg_wr = 0.
  - Otherwise: valid = ex_mem_valid_inst, result = extended load data for loads or ex_mem_alu_result for other instructions, dest and reg_wr passed through.
  - Stores: mem_wb_reg_wr = 0.

## Timing
- Reset values: all mem_wb_* = 0, mem_misalign_out = 0, state IDLE.
- Combinational outputs with no instruction present: req, stall = 0.
- Reset mid-access drops the access with no retry. The upstream pipeline is reset as well.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Store granted in cycle t: output at edge t+1.
  - Load granted at t, rvalid at t+k (k ≥ 1): output at the edge ending t+k.
  - Minimum load latency is 2 cycles.
- gnt and rvalid high in the same cycle while in IDLE: gnt is honoured and rvalid is ignored.
- Memory must not assert rvalid in the gnt cycle.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - Misaligned means half with a[0]=1, or word with a[1:0]≠0.
  - A misaligned access issues no request and does not stall.
  - mem_wb_valid = 0 and mem_wb_reg_wr = 0 for that instruction.
  - mem_misalign_out pulses 1 cycle later.
- MEM_ALIGN_CHECK_EN undefined:
  - misaligned is tied 0.
  - Half ignores a[0]; word ignores a[1:0].
  - mem_misalign_out is tied 0.

## Structure
- Shared package holds:
  - the mem-size encoding constants (MEM_BYTE, MEM_HALF, MEM_WORD),
  - the FSM state enum,
  - a typedef for the MEM/WB output bundle.
- One sub-module, `mem_load_align`: combinational lane select plus extension (rdata, a[1:0], funct3 → 32-bit result), reused by any future cache path.

## Test plan
- ALU op, alu_result=0x1234_5678, dest=5 → next edge mem_wb_valid=1, result=0x1234_5678, no req, no stall.
- SB at 0x103, rega=0x0000_00AB, gnt same cycle → be=1000, wdata=0xABAB_ABAB, addr=0x100, stall=0, mem_wb_reg_wr=0.
- LB at 0x101, gnt at t, rvalid at t+3 with rdata=0x0000_8000 → stall high t..t+2, three bubbles, then result=0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- LW with gnt held low 4 cycles → req stays high and stable, stall high, mem_wb_valid=0 throughout. After gnt and rvalid, the result equals rdata.
- Reset asserted in WAIT_RESP, then rvalid arrives → state IDLE, all outputs 0, response ignored.
- LH at 0x203 with MEM_ALIGN_CHECK_EN → no req, mem_misalign_out=1 next cycle, mem_wb_valid=0. Without the macro: addr=0x200, be=1100.
